// File: rtl/clk_div_multi_pkg.sv
// Shared defaults and helpers for the multi-channel clock divider.
package clk_div_pkg;

    localparam int NCH_DEF  = 4;
    localparam int W_DEF    = 8;
    localparam int DIV_IDLE = 0;

    // Channel-select width; never narrower than one bit.
    function automatic int ch_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// Divisor configuration handshake: master writes, divider (slave) accepts.
interface clk_div_multi_if
    import clk_div_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int W   = W_DEF
);

    logic                   cfg_valid;
    logic                   cfg_ready;
    logic [ch_w(NCH)-1:0]   cfg_ch;
    logic [W-1:0]           cfg_div;

    modport master (output cfg_valid, output cfg_ch, output cfg_div, input  cfg_ready);
    modport slave  (input  cfg_valid, input  cfg_ch, input  cfg_div, output cfg_ready);

endinterface

// File: rtl/clk_div_multi_ch.sv
// One divider channel: counter, pending-divisor slot, apply logic, output
// register and end-of-period tick. Define CLK_DIV_ODD50_EN to add a
// falling-edge register that stretches odd divisors to a 50% duty cycle.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_div,
    input  logic         sync,
    output logic         ready,
    output logic         clk_out,
    output logic         tick
);

    logic [W-1:0] div_q;
    logic [W-1:0] cnt_q;
    logic [W-1:0] pend_d;
    logic         pend_v;
    logic         hi_q;

    logic         idle;
    logic         at_end;
    logic         apply;
    logic [W-1:0] div_nxt;
    logic [W-1:0] cnt_nxt;

    // Period boundary detection; D-1 only matters once D is non-zero.
    always_comb begin
        idle   = (div_q == W'(DIV_IDLE));
        at_end = !idle && (cnt_q == div_q - W'(1));
        apply  = pend_v && (idle || at_end || sync);
    end

    // Next divisor and counter: apply first, then sync/wrap/idle force zero.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise a missed branch infers a latch.
        div_nxt = div_q;
        cnt_nxt = cnt_q + W'(1);
        if (apply) begin
            div_nxt = pend_d;
            cnt_nxt = '0;
        end else if (sync || idle || at_end) begin
            cnt_nxt = '0;
        end
    end

    // Channel state; hi_q is registered so clk_out never glitches.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            div_q  <= '0;
            cnt_q  <= '0;
            pend_v <= 1'b0;
            hi_q   <= 1'b0;
        end else begin
            div_q <= div_nxt;
            cnt_q <= cnt_nxt;
            hi_q  <= (cnt_nxt < (div_nxt >> 1));
            // A write needs an empty slot and an apply needs a full one,
            // so the two never collide on the same edge.
            if (wr_en) begin
                pend_v <= 1'b1;
            end else if (apply) begin
                pend_v <= 1'b0;
            end
        end
    end

    // Pending divisor data; qualified by pend_v, so it carries no reset.
    always_ff @(posedge clk) begin
        // NOTE: data storage guarded by a valid flag is left unreset; only
        // the flag itself must come out of reset in a known state.
        if (wr_en) begin
            pend_d <= wr_div;
        end
    end

    assign ready = !pend_v;
    assign tick  = at_end;

`ifdef CLK_DIV_ODD50_EN
    logic neg_q;
    logic odd_wide;

    // Half-cycle delayed copy of hi_q used to stretch odd periods.
    always_ff @(negedge clk) begin
        if (rst) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= hi_q;
        end
    end

    // Only odd divisors of 3 and up get the extra half cycle.
    always_comb begin
        odd_wide = div_q[0] && (div_q >= W'(3));
        clk_out  = hi_q | (odd_wide & neg_q);
    end
`else
    assign clk_out = hi_q;
`endif

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel clock divider top: decodes the divisor write channel,
// broadcasts sync and instantiates NCH independent channels.
// Optional feature macro: CLK_DIV_ODD50_EN (50% duty for odd divisors).
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int W   = W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    clk_div_multi_if.slave      cfg,
    input  logic                sync,
    output logic [NCH-1:0]      clk_out,
    output logic [NCH-1:0]      tick
);

    localparam int CW = ch_w(NCH);

    logic [NCH-1:0] ready_vec;
    logic [NCH-1:0] wr_en;

    // Ready follows the addressed channel; out-of-range writes are dropped.
    always_comb begin
        cfg.cfg_ready = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (cfg.cfg_ch == CW'(i)) begin
                cfg.cfg_ready = ready_vec[i];
            end
        end
    end

    // One-hot write strobe for the accepted channel.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            wr_en[i] = cfg.cfg_valid && (cfg.cfg_ch == CW'(i)) && ready_vec[i];
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        clk_div_ch #(.W(W)) u_ch (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (wr_en[g]),
            .wr_div  (cfg.cfg_div),
            .sync    (sync),
            .ready   (ready_vec[g]),
            .clk_out (clk_out[g]),
            .tick    (tick[g])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: a period/phase model checked every
// cycle, plus directed sequences with hand-computed literal expectations.
module tb_clk_div_multi;

    localparam int NCH = 4;
    localparam int W   = 8;

    logic           clk;
    logic           rst;
    logic           sync;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;

    clk_div_multi_if #(.NCH(NCH), .W(W)) cfg_if ();

    clk_div_multi #(.NCH(NCH), .W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .cfg     (cfg_if),
        .sync    (sync),
        .clk_out (clk_out),
        .tick    (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each channel is described by its divisor and the edge number at which
    // its current period train started; phase is plain modular arithmetic.
    int n = 0;
    int mdiv   [NCH];
    int mpend  [NCH];
    bit mpv    [NCH];
    int mstart [NCH];
    bit mhi_prev [NCH];

    function automatic int phase(input int c, input int nn);
        return (mdiv[c] == 0) ? 0 : (nn - mstart[c]) % mdiv[c];
    endfunction

    function automatic bit mhi(input int c, input int nn);
        return (mdiv[c] >= 2) && (phase(c, nn) < mdiv[c] / 2);
    endfunction

    function automatic bit mtick(input int c, input int nn);
        return (mdiv[c] != 0) && (phase(c, nn) == mdiv[c] - 1);
    endfunction

    always @(posedge clk) begin
        n = n + 1;
        for (int c = 0; c < NCH; c++) begin
            bit acc;
            bit last;
            acc = cfg_if.cfg_valid && (int'(cfg_if.cfg_ch) == c) && !mpv[c];
            if (rst) begin
                mdiv[c]     = 0;
                mpv[c]      = 1'b0;
                mstart[c]   = n;
                mhi_prev[c] = 1'b0;
            end else begin
                mhi_prev[c] = mhi(c, n - 1);
                last = mtick(c, n - 1);
                if (mpv[c] && (mdiv[c] == 0 || last || sync)) begin
                    mdiv[c]   = mpend[c];
                    mpv[c]    = 1'b0;
                    mstart[c] = n;
                end else if (sync) begin
                    mstart[c] = n;
                end
                if (acc) begin
                    mpend[c] = int'(cfg_if.cfg_div);
                    mpv[c]   = 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, shortly after each rising edge.
    always @(posedge clk) begin
        logic [NCH-1:0] exp_co;
        logic [NCH-1:0] exp_tk;
        #1;
        for (int c = 0; c < NCH; c++) begin
`ifdef CLK_DIV_ODD50_EN
            exp_co[c] = mhi(c, n) | ((mdiv[c] % 2 == 1) && (mdiv[c] >= 3) && mhi_prev[c]);
`else
            exp_co[c] = mhi(c, n);
`endif
            exp_tk[c] = mtick(c, n);
        end
        check("model_clk_out", 32'(clk_out), 32'(exp_co));
        check("model_tick", 32'(tick), 32'(exp_tk));
        check("model_cfg_ready", 32'(cfg_if.cfg_ready), 32'(!mpv[int'(cfg_if.cfg_ch)]));
    end

`ifdef CLK_DIV_ODD50_EN
    // After the falling edge the stretched output equals the rising-edge level.
    always @(negedge clk) begin
        logic [NCH-1:0] exp_co;
        #1;
        for (int c = 0; c < NCH; c++) exp_co[c] = mhi(c, n);
        check("model_clk_out_neg", 32'(clk_out), 32'(exp_co));
    end
`endif

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic wr(input int ch, input int d, output int stalls);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = 2'(ch);
        cfg_if.cfg_div   = 8'(d);
        stalls = 0;
        while (!cfg_if.cfg_ready && stalls < 100) begin
            step();
            stalls++;
        end
        if (stalls >= 100) check("wr_ready_timeout", 32'(cfg_if.cfg_ready), 32'd1);
        step();
        cfg_if.cfg_valid = 1'b0;
    endtask

    initial begin
        int st;
        logic [3:0] s4;
        logic [3:0] t4;
        logic [4:0] s5;
        logic [4:0] sn5;

        rst = 1'b1;
        sync = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ch    = '0;
        cfg_if.cfg_div   = '0;

        // Reset state
        step();
        step();
        check("rst_clk_out", 32'(clk_out), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        for (int c = 0; c < NCH; c++) begin
            cfg_if.cfg_ch = 2'(c);
            #1;
            check("rst_ready", 32'(cfg_if.cfg_ready), 32'd1);
        end
        @(negedge clk);
        rst = 1'b0;
        step();

        // D=4 on idle channel 0: 1,1,0,0 from the apply edge, tick on cnt 3
        wr(0, 4, st);
        for (int i = 0; i < 4; i++) begin
            step();
            s4[3-i] = clk_out[0];
            t4[3-i] = tick[0];
        end
        check("ch0_d4_clk", 32'(s4), 32'b1100);
        check("ch0_d4_tick", 32'(t4), 32'b0001);

        // D=5 on channel 1
        wr(1, 5, st);
        for (int i = 0; i < 5; i++) begin
            step();
            s5[4-i] = clk_out[1];
`ifdef CLK_DIV_ODD50_EN
            @(negedge clk);
            #1;
            sn5[4-i] = clk_out[1];
`else
            sn5[4-i] = clk_out[1];
`endif
        end
`ifdef CLK_DIV_ODD50_EN
        check("ch1_d5_pos", 32'(s5), 32'b11100);
        check("ch1_d5_neg", 32'(sn5), 32'b11000);
`else
        check("ch1_d5_pos", 32'(s5), 32'b11000);
        check("ch1_d5_pos_again", 32'(sn5), 32'b11000);
`endif

        // Channel 2 at D=6, write D=2 at cnt 2
        wr(2, 6, st);
        step();           // cnt 0
        step();           // cnt 1
        step();           // cnt 2
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = 2'd2;
        cfg_if.cfg_div   = 8'd2;
        check("ch2_ready_pre", 32'(cfg_if.cfg_ready), 32'd1);
        step();           // accepted, cnt 3
        cfg_if.cfg_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("ch2_ready_stall", 32'(cfg_if.cfg_ready), 32'd0);
            check("ch2_no_runt", 32'(clk_out[2]), 32'd0);
            step();
        end
        check("ch2_ready_applied", 32'(cfg_if.cfg_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            s4[3-i] = clk_out[2];
            step();
        end
        check("ch2_d2_clk", 32'(s4), 32'b1010);

        // Back-to-back writes to channel 3, then D=0
        wr(3, 4, st);
        wr(3, 8, st);
        check("ch3_stall_first", 32'(st), 32'd1);
        wr(3, 0, st);
        check("ch3_stall_second", 32'(st), 32'd3);
        repeat (12) step();
        check("ch3_idle_clk", 32'(clk_out[3]), 32'd0);
        check("ch3_idle_tick", 32'(tick[3]), 32'd0);

        // Channels at D=3, 4, 7 then sync
        wr(0, 3, st);
        wr(1, 4, st);
        wr(2, 7, st);
        repeat (20) step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        check("sync_rise", 32'(clk_out), 32'b0111);
        check("sync_tick", 32'(tick), 32'd0);
        step();
`ifdef CLK_DIV_ODD50_EN
        check("sync_next", 32'(clk_out), 32'b0111);
`else
        check("sync_next", 32'(clk_out), 32'b0110);
`endif

        // Reset mid-period
        step();
        rst = 1'b1;
        step();
        check("rst_mid_clk", 32'(clk_out), 32'd0);
        check("rst_mid_tick", 32'(tick), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check("post_rst_quiet", 32'({clk_out, tick}), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_div_multi.md
# clk_div_multi

Parametrised multi-channel clock divider, the successor to the single-channel 8-bit divider. Each of NCH channels divides `clk` by its own W-bit run-time divisor and produces a divided clock level plus a one-cycle end-of-period tick. Divisors load through a valid/ready handshake and take effect only at a period boundary, so `clk_out` never glitches. Sits next to the clock source, feeding peripheral timing and strobe generation.

## Interface
- NCH, 4, number of independent channels (1..16)
- W, 8, divisor width in bits (2..16)
- clk  in  1  system clock; all state is updated on its rising edge (the macro feature also uses the falling edge)
- rst  in  1  reset; one clock, synchronous, active-high
- cfg_valid  in  1  divisor write request
- cfg_ready  out  1  write can be accepted (combinational: pending slot of cfg_ch is empty)
- cfg_ch  in  $clog2(NCH) (min 1)  target channel
- cfg_div  in  W  new divisor D
- sync  in  1  restart all channels in phase
- clk_out  out  NCH  divided clock level per channel
- tick  out  NCH  one-cycle pulse per channel in the last cycle of each period

## Operation
- Per-channel state: active divisor div_q (W), counter cnt (W), pending divisor pend_d (W) with flag pend_v, output register hi_q.
- Write accepted on a rising edge with cfg_valid && cfg_ready: pend_d[cfg_ch] <= cfg_div, pend_v <= 1. cfg_ready = !pend_v[cfg_ch]. cfg_ch >= NCH: cfg_ready = 1 and the write is dropped.
- Apply point: a channel applies its pending divisor (div_q <= pend_d, cnt <= 0, pend_v <= 0) on an edge where pend_v is already 1 and one of these holds: the channel is idle (div_q == 0); cnt == div_q-1; or sync == 1.
- Running (D >= 2): cnt counts 0..D-1 and wraps. H = D>>1. Registered clk_out == (cnt < H), so the output is high for the first H cycles of each period. tick = (cnt == D-1).
- D == 1: tick is 1 every cycle and clk_out is 0.
- D == 0: the channel is idle; cnt is 0, clk_out is 0, tick is 0.
- sync: on an edge where sync == 1, every channel sets cnt <= 0, after applying any pending divisor. All running channels then start a period together.
- Simultaneous accept and apply point on the same channel and edge: the new value is stored as pending. It applies at the next apply point, never on that same edge.
- Width rule: all compares are on W bits unsigned. D-1 is evaluated only when D != 0.

## Timing
- Reset (rst high at a rising edge): div_q, cnt, pend_v, hi_q and the negedge register are all 0. Hence clk_out = 0, tick = 0 and cfg_ready = 1. Reset wins over every other input, including a write or sync on the same edge.
- Write latency to an idle channel: accepted at edge k, applied at edge k+1, clk_out high from edge k+1 (when H >= 1).
- Write latency to a running channel: applied at the first edge where cnt == D_old-1 after acceptance. The old period always completes.
- tick is combinational from registered state. It is high for the whole cycle in which cnt == D-1.
- Reset asserted mid-period: all outputs return to 0 at that edge. No partial pulse is generated afterwards.

## Configuration
- CLK_DIV_ODD50_EN defined: for odd D >= 3, clk_out = hi_q | neg_q, where neg_q is hi_q captured on the falling edge of clk. This gives a 50% duty cycle (high for H+0.5 cycles). For even D, clk_out = hi_q. neg_q is cleared when rst is sampled high at a falling edge.
- CLK_DIV_ODD50_EN undefined: no falling-edge logic is built. For odd D, clk_out is high for H cycles and low for H+1 cycles.

## Structure
- Package clk_div_pkg holds:
  - default NCH and W;
  - the channel-index width function;
  - constant DIV_IDLE = 0.
- Sub-module clk_div_ch: one channel, containing the counter, pending slot, apply logic, hi_q, the optional neg_q, and tick. The top level decodes cfg_ch and sync and generates NCH instances.

## Test plan
- Reset: with rst high for 2 cycles, require clk_out = 0, tick = 0 and cfg_ready = 1 on every channel.
- Write D=4 to channel 0 while it is idle: from the apply edge, clk_out reads 1,1,0,0 repeating, and tick is high once every 4 cycles, in the cycle with cnt == 3.
- Write D=5 to channel 1, with and without CLK_DIV_ODD50_EN:
  - undefined: high 2 cycles, low 3 cycles;
  - defined: high for 2.5 clk periods and low for 2.5, measured on clock edges.
- Channel 2 running at D=6: write D=2 at cnt == 2. cfg_ready then stays 0 until the edge that completes the current 6-cycle period. The period following that edge is 2 cycles long, with no runt pulse.
- Back-to-back writes to one channel: the second write stalls with cfg_ready = 0 until the first divisor is applied. Then write D=0: the channel idles with clk_out = 0 after its current period ends.
- Channels at D=3, 4 and 7: pulse sync. All cnt are 0 on the next edge, and all clk_out rise together. Asserting rst mid-period drives all outputs to 0 on the same edge.
